vram_slot_arbiter: RTL and testbench
====================================

Name: vram_slot_arbiter

Overview:
- Shares one single-port synchronous tile VRAM between the video tile fetcher and the Z80 CPU bus.
- Slot scheduling is driven by the beam position and blanking outputs of the video timing generator (HPOS/VPOS/HBLK/VBLK, all on PCLK).
- Video fetches own fixed slots in each 8-pixel group. The CPU gets every other slot, and all slots outside the fetch window, through a REQ/ACK handshake.
- Outputs are per-tile code/attribute bytes for the tile renderer plus CPU read data.

Parameters:
- AW, 11, VRAM address width; code plane at 0x000-0x3FF.
- DW, 8, VRAM data width.
- ATTR_BASE, 11'h400, base address of the attribute plane.

Ports:
- PCLK  in  1  pixel clock; sole clock.
- RESET  in  1  synchronous, active-high reset.
- HPOS  in  9  horizontal beam position from the timing generator.
- VPOS  in  9  vertical beam position.
- HBLK  in  1  horizontal blank (informational; the window is decoded from HPOS).
- VBLK  in  1  vertical blank.
- CPU_REQ  in  1  access request, level; held until CPU_ACK.
- CPU_WE  in  1  1 = write, 0 = read; stable while CPU_REQ is high.
- CPU_AD  in  AW  CPU address.
- CPU_DI  in  DW  CPU write data.
- CPU_DO  out  DW  CPU read data; valid when CPU_ACK = 1.
- CPU_ACK  out  1  one-cycle completion pulse.
- RAM_AD  out  AW  VRAM address.
- RAM_WE  out  1  VRAM write enable.
- RAM_DO  out  DW  VRAM write data.
- RAM_DI  in  DW  VRAM read data; one-cycle latency after the address.
- VID_CODE  out  8  latched tile code.
- VID_ATTR  out  8  latched tile attribute.
- VID_STB  out  1  one-cycle pulse when VID_CODE and VID_ATTR are updated as a pair.

Behaviour:
- Slot definition: slot = HPOS[2:0].
- Fetch window: FW = !VBLK && (HPOS < 256 || HPOS[8:3] == 6'h3F). HPOS 504..511 prefetches column 0.
- Fetch column: FC = (HPOS + 8)[7:3], computed in 9-bit arithmetic with wrap. Fetch row: FR = VPOS[7:3].
- Video slots, inside FW only:
  - slot 0 reads {FR, FC} (10 bits, zero-extended to AW).
  - slot 2 reads ATTR_BASE | {FR, FC}.
- All other slots, and every slot outside FW, are CPU-eligible. The video fetcher always wins; there is no CPU override.
- RAM_AD, RAM_WE and RAM_DO are combinational functions of the current slot, FW and the registered CPU state. The RAM samples on the closing edge.
- Video latch:
  - On the edge ending slot 1 with FW, VID_CODE <= RAM_DI.
  - On the edge ending slot 3 with FW, VID_ATTR <= RAM_DI and VID_STB <= 1 for exactly one cycle.
  - FW is evaluated per cycle. If the window closes mid-group, the pending latch is skipped and no VID_STB is issued.
- CPU FSM states: IDLE, PEND, RDWAIT, ACK, RELEASE.
  - IDLE: on CPU_REQ = 1, latch CPU_WE, CPU_AD and CPU_DI, then go to PEND. CPU signals are never used unlatched.
  - PEND: on a CPU-eligible cycle, drive RAM_AD = latched address.
    - Write: RAM_WE = 1 and RAM_DO = latched data for that cycle, then go to ACK.
    - Read: RAM_WE = 0, then go to RDWAIT.
  - RDWAIT: CPU_DO <= RAM_DI, then go to ACK. No RAM access is issued, so a video slot may coincide with this cycle.
  - ACK: CPU_ACK = 1 for one cycle, then go to RELEASE.
  - RELEASE: wait for CPU_REQ = 0, then go to IDLE. A held REQ never retriggers.
- Worst-case latency from REQ sampled to ACK is 5 cycles (REQ arrives at slot 7: latch, blocked by slot 0, issue in slot 1, RDWAIT, ACK).
- In non-access cycles, RAM_WE = 0 and RAM_AD = video address if FW, else the latched CPU address.
- Reset values: CPU_DO = 0, CPU_ACK = 0, VID_CODE = 0, VID_ATTR = 0, VID_STB = 0, FSM = IDLE, RAM_WE = 0.
- Reset mid-access: the access is aborted with no ACK, and RAM_WE is low from the reset cycle onward.

Decomposition:
- Shared package video_pkg holds:
  - the CPU FSM state enum;
  - SLOT_CODE = 3'd0 and SLOT_ATTR = 3'd2;
  - FW_END = 9'd256 and PREFETCH_HI = 6'h3F;
  - ATTR_BASE.
- One natural sub-module, vram_slot_decode: combinational FW, slot-type and video-address generation from HPOS/VPOS/VBLK. The FSM and latches stay in the top level.

Test Plan:
- Reset asserted while in PEND with a write pending -> no CPU_ACK; RAM_WE = 0 from the reset cycle; all outputs 0 the following cycle.
- VBLK = 0, VPOS = 16, HPOS sweeps 504..15, RAM model returns address LSBs -> RAM_AD = 0x040 at HPOS 504 and 0x440 at HPOS 506; VID_CODE = 0x40; VID_STB pulses once per group after slot 3; next group fetches 0x041.
- CPU write REQ arriving at slot 7 in FW, AD = 0x123, DI = 0xA5 -> slot 0 serves video; RAM_WE = 1 with RAM_AD = 0x123 and RAM_DO = 0xA5 in slot 1; CPU_ACK one cycle later.
- CPU read during VBLK = 1, AD = 0x7FF, RAM returns 0x5A -> RAM_AD = 0x7FF on the cycle after the latch; CPU_DO = 0x5A with CPU_ACK 2 cycles later; no VID_STB anywhere in the frame's VBLK.
- CPU_REQ held high for 20 cycles after ACK -> exactly one access and one ACK; a new access occurs only after REQ drops and rises again.
- Random CPU traffic over a full frame against a reference RAM model -> video reads never displaced; every REQ is ACKed within 5 cycles; read data matches the model.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants and types for the tile VRAM slot arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package video_pkg;

    // CPU access sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PEND    = 3'd1,
        ST_RDWAIT  = 3'd2,
        ST_ACK     = 3'd3,
        ST_RELEASE = 3'd4
    } cpu_state_t;

    // Slots within an 8-pixel group owned by the video fetcher
    localparam logic [2:0] SLOT_CODE = 3'd0;
    localparam logic [2:0] SLOT_ATTR = 3'd2;

    // Fetch window: HPOS below FW_END, plus the last group of the line
    // (HPOS[8:3] == PREFETCH_HI) which prefetches column 0 of the next line.
    localparam logic [8:0] FW_END      = 9'd256;
    localparam logic [5:0] PREFETCH_HI = 6'h3F;

    // Attribute plane sits directly above the 1 KiB code plane
    localparam logic [10:0] ATTR_BASE = 11'h400;

endpackage

// File: rtl/vram_slot_arbiter_if.sv
// CPU-side request/acknowledge bus into the VRAM slot arbiter.
// Latency: none (wiring only).
// Backpressure: CPU holds REQ (and stable WE/AD/DI) until a one-cycle ACK.
interface vram_slot_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 8
);
    logic          CPU_REQ;
    logic          CPU_WE;
    logic [AW-1:0] CPU_AD;
    logic [DW-1:0] CPU_DI;
    logic [DW-1:0] CPU_DO;
    logic          CPU_ACK;

    // CPU side drives the request, arbiter answers with data and ACK
    modport master (
        output CPU_REQ, CPU_WE, CPU_AD, CPU_DI,
        input  CPU_DO, CPU_ACK
    );

    modport slave (
        input  CPU_REQ, CPU_WE, CPU_AD, CPU_DI,
        output CPU_DO, CPU_ACK
    );
endinterface

// File: rtl/vram_slot_decode.sv
// Decodes beam position into fetch window, slot ownership and video address.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the video fetcher is never stalled.
module vram_slot_decode #(
    parameter int            AW        = 11,
    parameter logic [AW-1:0] ATTR_BASE = video_pkg::ATTR_BASE
) (
    input  logic [8:0]    hpos,
    input  logic [8:0]    vpos,
    input  logic          vblk,
    output logic          fw,
    output logic [2:0]    slot,
    output logic          vid_slot,
    output logic [AW-1:0] vid_ad
);

    logic [8:0]    hnext;
    logic [9:0]    tile;
    logic [AW-1:0] code_ad;
    logic          unused_bits;

    // Window, slot type and tile address of the group one ahead of the beam
    always_comb begin
        slot     = hpos[2:0];
        fw       = !vblk && ((hpos < video_pkg::FW_END) ||
                             (hpos[8:3] == video_pkg::PREFETCH_HI));
        // 9-bit wrap makes HPOS 504..511 point at column 0
        hnext    = hpos + 9'd8;
        tile     = {vpos[7:3], hnext[7:3]};
        code_ad  = AW'(tile);
        vid_slot = fw && ((slot == video_pkg::SLOT_CODE) ||
                          (slot == video_pkg::SLOT_ATTR));
        vid_ad   = (slot == video_pkg::SLOT_ATTR) ? (code_ad | ATTR_BASE) : code_ad;
    end

    // Row/column only need the tile-granular bits
    assign unused_bits = ^{vpos[8], vpos[2:0], hnext[8], hnext[2:0]};

endmodule

// File: rtl/vram_slot_arbiter.sv
// Shares a single-port tile VRAM between the video fetcher and the Z80 bus.
// Latency: video data latched 1 cycle after its slot; CPU REQ->ACK at most 5 cycles.
// Backpressure: video slots always win; CPU waits in PEND for an eligible slot.
module vram_slot_arbiter #(
    parameter int            AW        = 11,
    parameter int            DW        = 8,
    parameter logic [AW-1:0] ATTR_BASE = video_pkg::ATTR_BASE
) (
    input  logic            PCLK,
    input  logic            RESET,
    input  logic [8:0]      HPOS,
    input  logic [8:0]      VPOS,
    input  logic            HBLK,
    input  logic            VBLK,
    vram_slot_arbiter_if.slave cpu,
    output logic [AW-1:0]   RAM_AD,
    output logic            RAM_WE,
    output logic [DW-1:0]   RAM_DO,
    input  logic [DW-1:0]   RAM_DI,
    output logic [7:0]      VID_CODE,
    output logic [7:0]      VID_ATTR,
    output logic            VID_STB
);

    logic          fw;
    logic [2:0]    slot;
    logic          vid_slot;
    logic [AW-1:0] vid_ad;
    logic          cpu_access;
    logic          unused_hblk;

    video_pkg::cpu_state_t state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] ad_q, ad_d;
    logic [DW-1:0] di_q, di_d;
    logic [DW-1:0] cpu_do_q, cpu_do_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [7:0]    vid_code_q, vid_code_d;
    logic [7:0]    vid_attr_q, vid_attr_d;
    logic          vid_stb_q, vid_stb_d;

    vram_slot_decode #(
        .AW        (AW),
        .ATTR_BASE (ATTR_BASE)
    ) u_decode (
        .hpos     (HPOS),
        .vpos     (VPOS),
        .vblk     (VBLK),
        .fw       (fw),
        .slot     (slot),
        .vid_slot (vid_slot),
        .vid_ad   (vid_ad)
    );

    // The window is decoded from HPOS, so blanking is informational only
    assign unused_hblk = HBLK;

    // A CPU access happens only from PEND in a slot the fetcher does not own
    assign cpu_access = (state_q == video_pkg::ST_PEND) && !vid_slot;

    // RAM port: RESET gates the strobe so an aborted write never lands
    always_comb begin
        RAM_WE = !RESET && cpu_access && we_q;
        RAM_AD = (fw && !cpu_access) ? vid_ad : ad_q;
        RAM_DO = RAM_WE ? di_q : '0;
    end

    // Next-state for the CPU sequencer and the video latches
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        ad_d       = ad_q;
        di_d       = di_q;
        cpu_do_d   = cpu_do_q;
        vid_code_d = vid_code_q;
        vid_attr_d = vid_attr_q;
        vid_stb_d  = 1'b0;

        case (state_q)
            video_pkg::ST_IDLE: begin
                // Only latched copies of the CPU bus are ever used downstream
                if (cpu.CPU_REQ) begin
                    we_d    = cpu.CPU_WE;
                    ad_d    = cpu.CPU_AD;
                    di_d    = cpu.CPU_DI;
                    state_d = video_pkg::ST_PEND;
                end
            end
            video_pkg::ST_PEND: begin
                if (!vid_slot) begin
                    state_d = we_q ? video_pkg::ST_ACK : video_pkg::ST_RDWAIT;
                end
            end
            video_pkg::ST_RDWAIT: begin
                cpu_do_d = RAM_DI;
                state_d  = video_pkg::ST_ACK;
            end
            video_pkg::ST_ACK: begin
                state_d = video_pkg::ST_RELEASE;
            end
            video_pkg::ST_RELEASE: begin
                // A level REQ still high after ACK must not start a second access
                if (!cpu.CPU_REQ) begin
                    state_d = video_pkg::ST_IDLE;
                end
            end
            default: begin
                state_d = video_pkg::ST_IDLE;
            end
        endcase

        cpu_ack_d = (state_d == video_pkg::ST_ACK);

        // Data returned for slot 0/2 addresses arrives during slot 1/3;
        // a window closing mid-group simply skips the latch and the strobe.
        if (fw && (slot == 3'd1)) begin
            vid_code_d = 8'(RAM_DI);
        end
        if (fw && (slot == 3'd3)) begin
            vid_attr_d = 8'(RAM_DI);
            vid_stb_d  = 1'b1;
        end
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            state_q    <= video_pkg::ST_IDLE;
            we_q       <= 1'b0;
            ad_q       <= '0;
            di_q       <= '0;
            cpu_do_q   <= '0;
            cpu_ack_q  <= 1'b0;
            vid_code_q <= '0;
            vid_attr_q <= '0;
            vid_stb_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            ad_q       <= ad_d;
            di_q       <= di_d;
            cpu_do_q   <= cpu_do_d;
            cpu_ack_q  <= cpu_ack_d;
            vid_code_q <= vid_code_d;
            vid_attr_q <= vid_attr_d;
            vid_stb_q  <= vid_stb_d;
        end
    end

    assign cpu.CPU_DO  = cpu_do_q;
    assign cpu.CPU_ACK = cpu_ack_q;
    assign VID_CODE    = vid_code_q;
    assign VID_ATTR    = vid_attr_q;
    assign VID_STB     = vid_stb_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed bench for the VRAM slot arbiter with a behavioural RAM and beam.
// Latency: n/a.
// Backpressure: n/a.
module tb_vram_slot_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          PCLK = 1'b0;
    logic          RESET;
    logic [8:0]    HPOS, VPOS;
    logic          HBLK, VBLK;
    logic [AW-1:0] RAM_AD;
    logic          RAM_WE;
    logic [DW-1:0] RAM_DO, RAM_DI;
    logic [7:0]    VID_CODE, VID_ATTR;
    logic          VID_STB;

    int   n_chk = 0;
    int   n_pass = 0;
    int   h = 0;
    int   v = 0;
    bit   hold_v = 1'b0;
    int   stb_cnt = 0;
    bit   mem_init = 1'b1;
    logic [7:0] mem [0:2047];
    logic [7:0] ref_mem [0:2047];

    vram_slot_arbiter_if #(.AW(AW), .DW(DW)) cpu_if ();

    vram_slot_arbiter #(.AW(AW), .DW(DW), .ATTR_BASE(11'h400)) dut (
        .PCLK     (PCLK),
        .RESET    (RESET),
        .HPOS     (HPOS),
        .VPOS     (VPOS),
        .HBLK     (HBLK),
        .VBLK     (VBLK),
        .cpu      (cpu_if.slave),
        .RAM_AD   (RAM_AD),
        .RAM_WE   (RAM_WE),
        .RAM_DO   (RAM_DO),
        .RAM_DI   (RAM_DI),
        .VID_CODE (VID_CODE),
        .VID_ATTR (VID_ATTR),
        .VID_STB  (VID_STB)
    );

    always #5 PCLK = ~PCLK;

    // Single-port synchronous RAM, read-first, contents start as address LSBs
    always @(posedge PCLK) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'(i);
        end else if (RAM_WE) begin
            mem[RAM_AD] <= RAM_DO;
        end
        RAM_DI <= mem[RAM_AD];
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout n_chk=%0d expected_finish=1", n_chk);
        $fatal(1, "timeout");
    end

    task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit fw_m();
        return (v < 240) && ((h < 256) || (h >= 504));
    endfunction

    function automatic int exp_vad();
        int fc, tile;
        fc   = (((h + 8) % 512) / 8) % 32;
        tile = ((v / 8) % 32) * 32 + fc;
        return ((h % 8) == 2) ? (tile | 'h400) : tile;
    endfunction

    task drive();
        HPOS = 9'(h);
        VPOS = 9'(v);
        HBLK = (h >= 256);
        VBLK = (v >= 240);
    endtask

    task set_beam(input int nh, input int nv);
        h = nh;
        v = nv;
        drive();
        #1;
    endtask

    // One pixel clock: advance the beam and police every video-owned slot
    task cyc();
        @(posedge PCLK);
        #1;
        if (VID_STB === 1'b1) stb_cnt++;
        h++;
        if (h == 512) begin
            h = 0;
            if (!hold_v) v = (v + 1) % 262;
        end
        drive();
        #1;
        if (fw_m() && (((h % 8) == 0) || ((h % 8) == 2))) begin
            chk("vid_slot_ad", 32'(RAM_AD), exp_vad());
            chk("vid_slot_we", 32'(RAM_WE), 0);
        end
    endtask

    task automatic xact(input bit we, input logic [10:0] ad, input logic [7:0] di,
                        output logic [7:0] rd);
        int n;
        bit got;
        cpu_if.CPU_REQ = 1'b1;
        cpu_if.CPU_WE  = we;
        cpu_if.CPU_AD  = ad;
        cpu_if.CPU_DI  = di;
        got = 1'b0;
        n   = 0;
        rd  = 'x;
        while (!got && (n < 5)) begin
            cyc();
            n++;
            if (cpu_if.CPU_ACK === 1'b1) begin
                got = 1'b1;
                rd  = cpu_if.CPU_DO;
            end
        end
        chk("ack_within_5", 32'(got), 1);
        cpu_if.CPU_REQ = 1'b0;
        cyc();
        cyc();
        if (we) ref_mem[ad] = di;
    endtask

    initial begin
        int acks, wes, gap;
        bit rwe;
        logic [10:0] rad;
        logic [7:0]  rdi, rd, rexp;

        RESET = 1'b1;
        cpu_if.CPU_REQ = 1'b0;
        cpu_if.CPU_WE  = 1'b0;
        cpu_if.CPU_AD  = '0;
        cpu_if.CPU_DI  = '0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'(i);
        set_beam(0, 250);
        repeat (3) cyc();
        mem_init = 1'b0;
        chk("rst_ack", 32'(cpu_if.CPU_ACK), 0);
        chk("rst_cpu_do", 32'(cpu_if.CPU_DO), 0);
        chk("rst_vid_stb", 32'(VID_STB), 0);
        chk("rst_ram_we", 32'(RAM_WE), 0);

        // Write pending in PEND, then reset lands on the access cycle
        RESET = 1'b0;
        cpu_if.CPU_REQ = 1'b1;
        cpu_if.CPU_WE  = 1'b1;
        cpu_if.CPU_AD  = 11'h055;
        cpu_if.CPU_DI  = 8'h77;
        cyc();
        chk("pend_we", 32'(RAM_WE), 1);
        chk("pend_ad", 32'(RAM_AD), 'h055);
        RESET = 1'b1;
        #1;
        chk("rst_cut_we", 32'(RAM_WE), 0);
        cpu_if.CPU_REQ = 1'b0;
        cyc();
        chk("rst2_ack", 32'(cpu_if.CPU_ACK), 0);
        chk("rst2_we", 32'(RAM_WE), 0);
        chk("rst2_ad", 32'(RAM_AD), 0);
        chk("rst2_do", 32'(RAM_DO), 0);
        chk("rst2_cpu_do", 32'(cpu_if.CPU_DO), 0);
        chk("rst2_code", 32'(VID_CODE), 0);
        chk("rst2_attr", 32'(VID_ATTR), 0);
        chk("rst2_stb", 32'(VID_STB), 0);
        RESET = 1'b0;
        acks = 0;
        repeat (4) begin
            cyc();
            if (cpu_if.CPU_ACK === 1'b1) acks++;
        end
        chk("rst_no_ack", acks, 0);

        // Video sweep, VPOS fixed at 16 (row 2), HPOS 504..15
        hold_v = 1'b1;
        set_beam(504, 16);
        stb_cnt = 0;
        chk("sw_ad_504", 32'(RAM_AD), 'h040);
        cyc();
        cyc();
        chk("sw_ad_506", 32'(RAM_AD), 'h440);
        chk("sw_code_c0", 32'(VID_CODE), 'h40);
        cyc();
        cyc();
        chk("sw_stb_508", 32'(VID_STB), 1);
        chk("sw_attr_c0", 32'(VID_ATTR), 'h40);
        cyc();
        chk("sw_stb_once", 32'(VID_STB), 0);
        repeat (3) cyc();
        chk("sw_ad_0", 32'(RAM_AD), 'h041);
        cyc();
        cyc();
        chk("sw_ad_2", 32'(RAM_AD), 'h441);
        chk("sw_code_c1", 32'(VID_CODE), 'h41);
        repeat (14) cyc();
        chk("sw_stb_count", stb_cnt, 3);
        chk("sw_code_c2", 32'(VID_CODE), 'h42);
        chk("sw_attr_c2", 32'(VID_ATTR), 'h42);

        // CPU write arriving in slot 7 inside the window
        repeat (7) cyc();
        cpu_if.CPU_REQ = 1'b1;
        cpu_if.CPU_WE  = 1'b1;
        cpu_if.CPU_AD  = 11'h123;
        cpu_if.CPU_DI  = 8'hA5;
        cyc();
        chk("w7_slot0_we", 32'(RAM_WE), 0);
        chk("w7_slot0_ad", 32'(RAM_AD), 'h044);
        cyc();
        chk("w7_slot1_we", 32'(RAM_WE), 1);
        chk("w7_slot1_ad", 32'(RAM_AD), 'h123);
        chk("w7_slot1_do", 32'(RAM_DO), 'hA5);
        cyc();
        chk("w7_ack", 32'(cpu_if.CPU_ACK), 1);
        chk("w7_vid_code", 32'(VID_CODE), 'h44);
        cpu_if.CPU_REQ = 1'b0;
        cyc();
        chk("w7_ack_pulse", 32'(cpu_if.CPU_ACK), 0);
        cyc();
        chk("w7_stb", 32'(VID_STB), 1);
        chk("w7_vid_attr", 32'(VID_ATTR), 'h44);
        ref_mem[11'h123] = 8'hA5;
        hold_v = 1'b0;

        // Vertical blank: write then read back the top address
        set_beam(100, 240);
        stb_cnt = 0;
        xact(1'b1, 11'h7FF, 8'h5A, rd);
        cpu_if.CPU_REQ = 1'b1;
        cpu_if.CPU_WE  = 1'b0;
        cpu_if.CPU_AD  = 11'h7FF;
        cyc();
        chk("vb_rd_ad", 32'(RAM_AD), 'h7FF);
        chk("vb_rd_we", 32'(RAM_WE), 0);
        cyc();
        chk("vb_rdwait_ack", 32'(cpu_if.CPU_ACK), 0);
        cyc();
        chk("vb_rd_ack", 32'(cpu_if.CPU_ACK), 1);
        chk("vb_rd_data", 32'(cpu_if.CPU_DO), 'h5A);
        cpu_if.CPU_REQ = 1'b0;
        cyc();
        cyc();
        xact(1'b0, 11'h123, 8'h00, rd);
        chk("vb_rd_123", 32'(rd), 'hA5);
        xact(1'b0, 11'h055, 8'h00, rd);
        chk("vb_aborted_wr", 32'(rd), 'h55);

        // REQ held high long after ACK: one access only
        cpu_if.CPU_REQ = 1'b1;
        cpu_if.CPU_WE  = 1'b1;
        cpu_if.CPU_AD  = 11'h0AB;
        cpu_if.CPU_DI  = 8'h3C;
        acks = 0;
        wes  = 0;
        repeat (24) begin
            cyc();
            if (cpu_if.CPU_ACK === 1'b1) acks++;
            if (RAM_WE === 1'b1) wes++;
        end
        chk("held_acks", acks, 1);
        chk("held_writes", wes, 1);
        cpu_if.CPU_REQ = 1'b0;
        cyc();
        cyc();
        ref_mem[11'h0AB] = 8'h3C;
        xact(1'b0, 11'h0AB, 8'h00, rd);
        chk("held_rd1", 32'(rd), 'h3C);
        xact(1'b1, 11'h0AB, 8'hC3, rd);
        xact(1'b0, 11'h0AB, 8'h00, rd);
        chk("held_rd2", 32'(rd), 'hC3);
        chk("vb_no_stb", stb_cnt, 0);

        // Random traffic across four visible lines and one blank line
        set_beam(0, 236);
        stb_cnt = 0;
        while (v < 240) begin
            rwe  = 1'($urandom_range(0, 1));
            rad  = 11'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? 11'h7F0 : 11'h000);
            rdi  = 8'($urandom_range(0, 255));
            rexp = ref_mem[rad];
            xact(rwe, rad, rdi, rd);
            if (!rwe) chk("rnd_rd", 32'(rd), 32'(rexp));
            gap = $urandom_range(0, 3);
            repeat (gap) cyc();
        end
        while (!((v == 241) && (h == 0))) cyc();
        chk("rnd_stb_count", stb_cnt, 132);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
